dna_reader: RTL

- Autonomous reader for the FPGA device DNA. It replaces eCPU bit-banging of the CTRL_DNA_CLK, CTRL_DNA_READ and CTRL_DNA_SHIFT control bits.
- Sits directly downstream of the DNA_PORT primitive. Drives its CLK/READ/SHIFT pins, shifts out the 57-bit DNA, and holds it for the CPU parallel-port input mux as four 16-bit words.
- Runs on cpu_clk, the 16.368 MHz GPS TCXO.

---
 rtl/dna_reader_pkg.sv | 24 ++
 rtl/dna_reader_if.sv | 26 ++
 rtl/dna_reader_clk_div.sv | 29 ++
 rtl/dna_reader.sv | 129 ++++++++++++
 4 files changed

// File: rtl/dna_reader_pkg.sv
// Shared constants for the DNA_PORT reader: sizes, CPU op decodes, word selects, FSM states.
package dna_reader_pkg;

  localparam int DNA_BITS = 57;
  localparam int WORD_W   = 16;

  // CPU op decodes that produce the start event and the word-select reads
  localparam logic [5:0] OP_DNA_START = 6'h30;
  localparam logic [5:0] OP_DNA_RD    = 6'h31;

  localparam logic [1:0] SEL_W0 = 2'd0;
  localparam logic [1:0] SEL_W1 = 2'd1;
  localparam logic [1:0] SEL_W2 = 2'd2;
  localparam logic [1:0] SEL_W3 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_SHIFT  = 3'd3,
    ST_DONE   = 3'd4
  } dna_state_e;

endpackage

// File: rtl/dna_reader_if.sv
// Control/readout bundle between the CPU/DNA_PORT side and the DNA reader.
interface dna_reader_if;
  import dna_reader_pkg::*;

  logic                i_start;
  logic                i_dna_dout;
  logic [1:0]          i_sel;
  logic                o_dna_clk;
  logic                o_dna_read;
  logic                o_dna_shift;
  logic                o_busy;
  logic                o_valid;
  logic [WORD_W-1:0]   o_rd_word;
  logic [DNA_BITS-1:0] o_dna_value;

  modport slave (
    input  i_start, i_dna_dout, i_sel,
    output o_dna_clk, o_dna_read, o_dna_shift, o_busy, o_valid, o_rd_word, o_dna_value
  );

  modport master (
    output i_start, i_dna_dout, i_sel,
    input  o_dna_clk, o_dna_read, o_dna_shift, o_busy, o_valid, o_rd_word, o_dna_value
  );

endinterface

// File: rtl/dna_reader_clk_div.sv
// Half-period tick generator for slow bit-banged peripherals; tick on the last count of CLK_DIV.
module dna_reader_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             w_last;

  assign w_last = (r_div == DIV_LAST);
  assign o_tick = i_en & w_last;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_div <= '0;
    end else if (i_en) begin
      r_div <= w_last ? '0 : r_div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/dna_reader.sv
// Autonomous DNA_PORT reader: loads, shifts out the device DNA MSB first, and muxes it as CPU words.
//
// state  | meaning
// IDLE   | waiting for start, pins low, result held
// LOAD   | READ high, one full dna_clk period to load the primitive
// SAMPLE | one cycle: capture DOUT, decide shift or done
// SHIFT  | SHIFT high, one full dna_clk period to advance the primitive
// DONE   | one cycle: drop busy, raise valid
module dna_reader
  import dna_reader_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  dna_reader_if.slave bus
);

  localparam int CNT_W = $clog2(DNA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DNA_BITS - 1);

  dna_state_e          r_state;
  logic [CNT_W-1:0]    r_bitcnt;
  logic                r_dna_clk;
  logic                r_dna_read;
  logic                r_dna_shift;
  logic                r_busy;
  logic                r_valid;
  logic [DNA_BITS-1:0] r_dna_value;
  logic [WORD_W-1:0]   w_rd_word;
  logic                w_tick;
  logic                w_div_run;

  // Divider only runs while a dna_clk period is in progress, so each period starts from zero
  assign w_div_run = (r_state == ST_LOAD) || (r_state == ST_SHIFT);

  dna_reader_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (~w_div_run),
    .i_en   (w_div_run),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bitcnt    <= '0;
      r_dna_clk   <= 1'b0;
      r_dna_read  <= 1'b0;
      r_dna_shift <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_dna_value <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_busy      <= 1'b1;
            r_valid     <= 1'b0;
            r_dna_value <= '0;
            r_bitcnt    <= '0;
            r_dna_read  <= 1'b1;
            r_state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_tick) begin
            if (!r_dna_clk) begin
              r_dna_clk <= 1'b1;
            end else begin
              r_dna_clk  <= 1'b0;
              r_dna_read <= 1'b0;
              r_state    <= ST_SAMPLE;
            end
          end
        end
        ST_SAMPLE: begin
          r_dna_value <= {r_dna_value[DNA_BITS-2:0], bus.i_dna_dout};
          r_bitcnt    <= r_bitcnt + 1'b1;
          if (r_bitcnt == CNT_LAST) begin
            r_state <= ST_DONE;
          end else begin
            r_dna_shift <= 1'b1;
            r_state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_tick) begin
            if (!r_dna_clk) begin
              r_dna_clk <= 1'b1;
            end else begin
              r_dna_clk   <= 1'b0;
              r_dna_shift <= 1'b0;
              r_state     <= ST_SAMPLE;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_valid <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Readout is live during a read so the CPU can observe the partial shift
  always_comb begin
    w_rd_word = '0;
    case (bus.i_sel)
      SEL_W0:  w_rd_word = r_dna_value[15:0];
      SEL_W1:  w_rd_word = r_dna_value[31:16];
      SEL_W2:  w_rd_word = r_dna_value[47:32];
      SEL_W3:  w_rd_word = {7'b0, r_dna_value[56:48]};
      default: w_rd_word = '0;
    endcase
  end

  assign bus.o_dna_clk   = r_dna_clk;
  assign bus.o_dna_read  = r_dna_read;
  assign bus.o_dna_shift = r_dna_shift;
  assign bus.o_busy      = r_busy;
  assign bus.o_valid     = r_valid;
  assign bus.o_rd_word   = w_rd_word;
  assign bus.o_dna_value = r_dna_value;

endmodule
